fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_unit_buffer.sv | 49 ++++
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared processor definitions: default widths, opcode field bounds and
// the fetch sequencer state encoding.
package fetch_unit_pkg;

  localparam int INSTR_W_DEF = 19;
  localparam int ADDR_W_DEF  = 12;

  // Opcode field position inside an instruction word
  localparam int OPC_HI = 18;
  localparam int OPC_LO = 13;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_buffer.sv
// Two-entry FIFO holding fetched {instr, pc} pairs; head data reads as zero
// when empty so the outputs idle at zero.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int W = INSTR_W_DEF + ADDR_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign empty   = (cnt == 2'd0);
  assign full    = (cnt == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues single-cycle-latency memory reads, buffers the
// responses and handles branch redirects with a one-cycle flush.
//
// state | meaning
// RUN   | normal sequential fetch, requests gated by buffer space
// FLUSH | cycle after a redirect; buffer empty, request at new PC
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc
);

  fetch_state_t              state_q;
  logic [ADDR_W-1:0]         pc_q;
  logic [ADDR_W-1:0]         req_pc_q;
  logic                      in_flight_q;
  logic                      pop;
  logic                      push;
  logic                      space_ok;
  logic                      buf_full;
  logic                      buf_empty;
  logic [INSTR_W+ADDR_W-1:0] head;

  assign pop = instr_valid && instr_ready;

  // Occupancy plus in-flight minus pop must stay below two; with two slots
  // that leaves room unless the buffer is full, or holds one with one in flight.
  assign space_ok = pop || !(buf_full || (!buf_empty && in_flight_q));

  assign imem_req  = !rst && !redirect_valid && ((state_q == FLUSH) || space_ok);
  assign imem_addr = pc_q;

  // A response landing in a redirect cycle is dropped by the clear.
  assign push = in_flight_q && !redirect_valid;

  fetch_buffer #(.W(INSTR_W + ADDR_W)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata ({imem_rdata, req_pc_q}),
    .full  (buf_full),
    .empty (buf_empty),
    .head  (head)
  );

  assign instr_valid = !buf_empty;
  assign instr       = head[INSTR_W+ADDR_W-1:ADDR_W];
  assign instr_pc    = head[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= '0;
      req_pc_q    <= '0;
      in_flight_q <= 1'b0;
    end else begin
      in_flight_q <= imem_req;
      if (imem_req) req_pc_q <= pc_q;
      if (redirect_valid) begin
        state_q <= FLUSH;
        pc_q    <= redirect_pc;
      end else begin
        state_q <= RUN;
        if (imem_req) pc_q <= pc_q + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle-exact vector table, then randomized traffic
// checked against a delivered-stream reference model.
module tb_fetch_unit;

  localparam int AW = 12;
  localparam int IW = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;

  fetch_unit #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] mem [1 << AW];

  // One-cycle read latency; garbage when no request so a bogus push shows up.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem[imem_addr];
    else          imem_rdata <= IW'($urandom);
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  typedef struct {
    logic          r;
    logic          rv;
    logic [AW-1:0] rpc;
    logic          rdy;
    int            mode;   // 0 skip, 1 normal, 2 normal + idle zeros, 3 req only
    logic          ereq;
    logic [AW-1:0] eaddr;
    logic          evalid;
    logic [AW-1:0] epc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rv, input logic [AW-1:0] rpc, input logic rdy,
                     input int mode, input logic ereq, input logic [AW-1:0] eaddr,
                     input logic evalid, input logic [AW-1:0] epc);
    vec_t v;
    v.r = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.mode = mode;
    v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.epc = epc;
    vecs.push_back(v);
  endtask

  task automatic norm(input logic rdy, input logic ereq, input logic [AW-1:0] eaddr,
                      input logic evalid, input logic [AW-1:0] epc);
    add(1'b0, 1'b0, '0, rdy, 1, ereq, eaddr, evalid, epc);
  endtask

  task automatic redir(input logic [AW-1:0] rpc, input logic evalid, input logic [AW-1:0] epc);
    add(1'b0, 1'b1, rpc, 1'b1, 1, 1'b0, '0, evalid, epc);
  endtask

  // Reference model state for the random phase
  logic [AW-1:0] exp_next;
  int            gap;
  logic          hold;
  logic [AW-1:0] hold_pc;
  logic [IW-1:0] hold_instr;

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    for (int i = 0; i < (1 << AW); i++) mem[i] = IW'(i);

    add(1'b1, 1'b0, '0, 1'b1, 2, 1'b0, '0, 1'b0, '0);
    // reset release, stall five cycles on the first instruction
    norm(1, 1, 12'h000, 0, 12'h000);
    norm(1, 1, 12'h001, 0, 12'h000);
    for (int i = 0; i < 5; i++) norm(0, 0, 12'h000, 1, 12'h000);
    norm(1, 1, 12'h002, 1, 12'h000);
    norm(1, 1, 12'h003, 1, 12'h001);
    norm(1, 1, 12'h004, 1, 12'h002);
    norm(1, 1, 12'h005, 1, 12'h003);
    // single redirect; the popped 0x004 still counts
    redir(12'h100, 1, 12'h004);
    norm(1, 1, 12'h100, 0, 12'h000);
    norm(1, 1, 12'h101, 0, 12'h000);
    norm(1, 1, 12'h102, 1, 12'h100);
    norm(1, 1, 12'h103, 1, 12'h101);
    // back-to-back redirects
    redir(12'h200, 1, 12'h102);
    redir(12'h300, 0, 12'h000);
    norm(1, 1, 12'h300, 0, 12'h000);
    norm(1, 1, 12'h301, 0, 12'h000);
    norm(1, 1, 12'h302, 1, 12'h300);
    norm(1, 1, 12'h303, 1, 12'h301);
    // address wrap
    redir(12'hFFE, 1, 12'h302);
    norm(1, 1, 12'hFFE, 0, 12'h000);
    norm(1, 1, 12'hFFF, 0, 12'h000);
    norm(1, 1, 12'h000, 1, 12'hFFE);
    norm(1, 1, 12'h001, 1, 12'hFFF);
    norm(1, 1, 12'h002, 1, 12'h000);
    norm(1, 1, 12'h003, 1, 12'h001);
    // reset with one buffered and one in flight
    add(1'b1, 1'b0, '0, 1'b1, 3, 1'b0, '0, 1'b0, '0);
    add(1'b0, 1'b0, '0, 1'b1, 2, 1'b1, 12'h000, 1'b0, '0);
    norm(1, 1, 12'h001, 0, 12'h000);
    norm(1, 1, 12'h002, 1, 12'h000);
    norm(0, 0, 12'h000, 1, 12'h001);
    norm(0, 0, 12'h000, 1, 12'h001);
    // reset with the buffer full
    add(1'b1, 1'b0, '0, 1'b0, 3, 1'b0, '0, 1'b0, '0);
    add(1'b0, 1'b0, '0, 1'b1, 2, 1'b1, 12'h000, 1'b0, '0);
    norm(1, 1, 12'h001, 0, 12'h000);
    norm(1, 1, 12'h002, 1, 12'h000);

    repeat (3) @(posedge clk);
    #1;
    foreach (vecs[k]) begin
      cyc = k;
      rst = vecs[k].r; redirect_valid = vecs[k].rv;
      redirect_pc = vecs[k].rpc; instr_ready = vecs[k].rdy;
      @(negedge clk);
      if (vecs[k].mode != 0) chk("imem_req", 32'(imem_req), 32'(vecs[k].ereq));
      if (vecs[k].mode == 1 || vecs[k].mode == 2) begin
        if (vecs[k].ereq) chk("imem_addr", 32'(imem_addr), 32'(vecs[k].eaddr));
        chk("instr_valid", 32'(instr_valid), 32'(vecs[k].evalid));
        if (vecs[k].evalid) begin
          chk("instr_pc", 32'(instr_pc), 32'(vecs[k].epc));
          chk("instr", 32'(instr), 32'(vecs[k].epc));
        end else if (vecs[k].mode == 2) begin
          chk("idle_instr", 32'(instr), 32'h0);
          chk("idle_pc", 32'(instr_pc), 32'h0);
        end
      end
      @(posedge clk);
      #1;
    end

    // Randomized phase
    rst = 1'b1; redirect_valid = 1'b0; instr_ready = 1'b1;
    for (int i = 0; i < (1 << AW); i++) mem[i] = IW'($urandom);
    repeat (2) @(posedge clk);
    #1;
    exp_next = '0; gap = 0; hold = 1'b0; hold_pc = '0; hold_instr = '0;
    for (int c = 0; c < 4000; c++) begin
      cyc = 1000 + c;
      rst = ($urandom_range(0, 199) == 0);
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc = ($urandom_range(0, 1) == 0) ? AW'($urandom) : AW'(12'hFFC + AW'($urandom_range(0, 3)));
      @(negedge clk);
      if (rst) begin
        chk("rst_req", 32'(imem_req), 32'h0);
        exp_next = '0; gap = 0; hold = 1'b0;
      end else begin
        if (redirect_valid) chk("redir_req", 32'(imem_req), 32'h0);
        if (hold) begin
          chk("hold_valid", 32'(instr_valid), 32'h1);
          chk("hold_pc", 32'(instr_pc), 32'(hold_pc));
          chk("hold_instr", 32'(instr), 32'(hold_instr));
        end
        if (instr_valid) gap = 0;
        else gap++;
        chk("bubble_gap_le2", 32'(gap > 2), 32'h0);
        if (instr_valid && instr_ready) begin
          chk("stream_pc", 32'(instr_pc), 32'(exp_next));
          chk("stream_instr", 32'(instr), 32'(mem[exp_next]));
          exp_next = exp_next + AW'(1);
        end
        if (redirect_valid) begin
          exp_next = redirect_pc;
          gap = 0;
        end
        hold = instr_valid && !instr_ready && !redirect_valid;
        hold_pc = instr_pc;
        hold_instr = instr;
      end
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
